// File: rtl/cpu_pkg.sv
// Shared datapath definitions: ALU opcodes, writeback target codes and the
// writeback FSM state type.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SHRA = 5'd7;
  localparam logic [4:0] OP_ROR  = 5'd8;
  localparam logic [4:0] OP_ROL  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_NEG  = 5'd12;
  localparam logic [4:0] OP_XOR  = 5'd13;
  localparam logic [4:0] OP_NOR  = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;

  localparam logic [1:0] TGT_GPR = 2'd0;
  localparam logic [1:0] TGT_LO  = 2'd1;
  localparam logic [1:0] TGT_HI  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  function automatic logic op_defined(input logic [4:0] op);
    return (op != 5'd0) && (op <= OP_NOT);
  endfunction

  function automatic logic op_two_beat(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_writeback_z_reg64.sv
// 64-bit Z capture register (z_hi:z_lo) with load enable and synchronous clear.
module z_reg64 (
  input  logic        clk,
  input  logic        clr,
  input  logic        i_load,
  input  logic [63:0] i_d,
  output logic [63:0] o_q
);

  logic [63:0] r_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures the 64-bit result into Z and sequences it onto
// the 32-bit writeback bus in one or two beats, maintaining HI/LO.
//
// state    | meaning
// ST_IDLE  | c_ready high, waiting for a result from the ALU
// ST_BEAT0 | first (or only) beat presented on the writeback bus
// ST_BEAT1 | second beat of mul/div, targets HI
// ST_DONE  | one-cycle done pulse, then back to IDLE
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             c_valid,
  output logic             c_ready,
  input  logic [4:0]       opcode,
  input  logic [63:0]      C,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [1:0]       wb_tgt,
  output logic             done,
  output logic             err,
  output logic [31:0]      hi_q,
  output logic [31:0]      lo_q,
  output logic [CNT_W-1:0] wb_count
);

  wb_state_e        r_state;
  logic [4:0]       r_op;
  logic             r_c_ready;
  logic             r_wb_valid;
  logic [1:0]       r_wb_tgt;
  logic             r_sel_hi;
  logic             r_done;
  logic             r_err;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [CNT_W-1:0] r_wb_count;

  logic             w_z_load;
  logic [63:0]      w_z;
  logic [31:0]      w_wb_data;
  logic             w_beat_acc;

  assign w_z_load   = (r_state == ST_IDLE) && c_valid;
  assign w_beat_acc = r_wb_valid && wb_ready;
  // Beat data is a plain slice of Z; r_sel_hi picks which half this beat carries.
  assign w_wb_data  = r_sel_hi ? w_z[63:32] : w_z[31:0];

  z_reg64 u_z_reg (
    .clk    (clk),
    .clr    (clr),
    .i_load (w_z_load),
    .i_d    (C),
    .o_q    (w_z)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_c_ready  <= 1'b1;
      r_wb_valid <= 1'b0;
      r_wb_tgt   <= TGT_GPR;
      r_sel_hi   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_wb_count <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_beat_acc) begin
        if (r_wb_count != {CNT_W{1'b1}}) begin
          r_wb_count <= r_wb_count + CNT_W'(1);
        end
        if (r_wb_tgt == TGT_LO) begin
          r_lo <= w_wb_data;
        end else if (r_wb_tgt == TGT_HI) begin
          r_hi <= w_wb_data;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (c_valid) begin
            r_op <= opcode;
            if (op_defined(opcode)) begin
              r_state    <= ST_BEAT0;
              r_c_ready  <= 1'b0;
              r_wb_valid <= 1'b1;
              r_wb_tgt   <= op_two_beat(opcode) ? TGT_LO : TGT_GPR;
              r_sel_hi   <= (opcode == OP_DIV);
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_BEAT0: begin
          if (wb_ready) begin
            if (op_two_beat(r_op)) begin
              r_state  <= ST_BEAT1;
              r_wb_tgt <= TGT_HI;
              // div puts the quotient (z_hi) in LO and the remainder (z_lo) in HI
              r_sel_hi <= (r_op == OP_MUL);
            end else begin
              r_state    <= ST_DONE;
              r_wb_valid <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (wb_ready) begin
            r_state    <= ST_DONE;
            r_wb_valid <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_c_ready <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_c_ready  <= 1'b1;
          r_wb_valid <= 1'b0;
        end
      endcase
    end
  end

  assign c_ready  = r_c_ready;
  assign wb_valid = r_wb_valid;
  assign wb_data  = w_wb_data;
  assign wb_tgt   = r_wb_tgt;
  assign done     = r_done;
  assign err      = r_err;
  assign hi_q     = r_hi;
  assign lo_q     = r_lo;
  assign wb_count = r_wb_count;

endmodule
